// File: rtl/seven_seg_scanner.sv
// Six-digit multiplexed seven-segment scanner for the clock core.
// Ports: clk, reset_n, digi_clock/AM/lamp_test in; an/seg/dp out (active-low).
module seven_seg_scanner #(
  parameter int DWELL_CYCLES = 166,
  parameter int BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] digi_clock,
  input  logic        AM,
  input  logic        lamp_test,
  output logic [5:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int CW =
    (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] BLK_END =
    CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_END =
    CW'(DWELL_CYCLES - 1);
  localparam logic [2:0] LAST_IDX = 3'd5;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [23:0]     snap_q, snap_d;
  logic            am_q, am_d;
  logic [5:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic [5:0][3:0] digits;
  logic [3:0]      nib;

  function automatic logic [6:0] seg_of(
    input logic [3:0] n
  );
    logic [6:0] s;
    unique case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Slot timing: cnt runs 0..DWELL-1 across
  // the whole slot, blank first then drive.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CW'(1);
    snap_d  = snap_q;
    am_d    = am_q;
    // Frame-start capture keeps a frame coherent.
    if (state_q == BLANK && idx_q == 3'd0 &&
        cnt_q == '0) begin
      snap_d = digi_clock;
      am_d   = AM;
    end
    unique case (state_q)
      BLANK: begin
        if (cnt_q == BLK_END) state_d = DRIVE;
      end
      DRIVE: begin
        if (cnt_q == SLOT_END) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == LAST_IDX) ?
                    3'd0 : idx_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  // Outputs are decoded from the next state so
  // they register on the edge that enters it.
  always_comb begin
    digits = snap_d;
    nib    = digits[LAST_IDX - idx_d];
    an_d   = 6'h3F;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    if (state_d == DRIVE) begin
      an_d  = ~(6'b000001 << idx_d);
      seg_d = seg_of(nib);
      if (idx_d == 3'd0 && nib == 4'd0)
        seg_d = 7'h7F;
      unique case (1'b1)
        (idx_d == 3'd1 || idx_d == 3'd3):
          dp_d = snap_d[0];
        (idx_d == LAST_IDX):
          dp_d = am_d;
        default:
          dp_d = 1'b1;
      endcase
      if (lamp_test) begin
        seg_d = 7'h00;
        dp_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= BLANK;
      idx_q   <= 3'd0;
      cnt_q   <= '0;
      snap_q  <= 24'h0;
      am_q    <= 1'b0;
      an_q    <= 6'h3F;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      am_q    <= am_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: directed + random
// stimulus against a frame-position reference model.
module tb_seven_seg_scanner;

  localparam int DW    = 8;
  localparam int BW    = 2;
  localparam int FRAME = 6 * DW;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] digi_clock = 24'h0;
  logic        AM = 1'b0;
  logic        lamp_test = 1'b0;
  logic [5:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int failures = 0;
  int pos = 0;
  logic [23:0] m_snap = 24'h0;
  logic        m_am = 1'b0;

  logic [6:0] seg_tab [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100,
    7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000,
    7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111,
    7'b0111111
  };

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .digi_clock(digi_clock),
    .AM(AM),
    .lamp_test(lamp_test),
    .an(an),
    .seg(seg),
    .dp(dp)
  );

  task automatic chk(
    input string       tag,
    input logic [13:0] obs,
    input logic [13:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h",
             tag, obs, exp);
    end
  endtask

  // Expected {an,seg,dp} once the frame is at
  // position p (cycles since frame start).
  function automatic logic [13:0] model_out(
    input int   p,
    input logic lamp
  );
    int         slot;
    int         w;
    logic [3:0] d;
    logic [5:0] a;
    logic [6:0] s;
    logic       dd;
    slot = p / DW;
    w    = p % DW;
    if (w < BW) return {6'h3F, 7'h7F, 1'b1};
    a       = 6'h3F;
    a[slot] = 1'b0;
    d  = m_snap[23 - 4*slot -: 4];
    s  = seg_tab[d];
    if (slot == 0 && d == 4'd0) s = 7'h7F;
    dd = 1'b1;
    if (slot == 1 || slot == 3) dd = m_snap[0];
    if (slot == 5) dd = m_am;
    if (lamp) begin
      s  = 7'h00;
      dd = 1'b0;
    end
    return {a, s, dd};
  endfunction

  task automatic tick(input string tag);
    logic lamp_e;
    @(posedge clk);
    if (pos == 0) begin
      m_snap = digi_clock;
      m_am   = AM;
    end
    lamp_e = lamp_test;
    pos    = (pos + 1) % FRAME;
    @(negedge clk);
    chk(tag, {an, seg, dp}, model_out(pos, lamp_e));
  endtask

  task automatic run_to(input int p, input string tag);
    int n;
    n = 0;
    while (pos != p && n < FRAME) begin
      tick(tag);
      n++;
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    digi_clock = 24'h123456;
    AM         = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hold", {an, seg, dp},
        {6'h3F, 7'h7F, 1'b1});

    pos     = 0;
    reset_n = 1'b1;
    tick("rel_e1");
    chk("first_blank", {an, seg, dp},
        {6'h3F, 7'h7F, 1'b1});
    tick("rel_e2");
    chk("idx0_at2", {an, seg, dp},
        {6'h3E, 7'b1111001, 1'b1});
    run_to(10, "f1");
    chk("pm_idx1", {an, seg, dp},
        {6'h3D, 7'b0100100, 1'b0});
    run_to(42, "f1");
    chk("pm_idx5", {an, seg, dp},
        {6'h1F, 7'b0000010, 1'b0});
    run_to(0, "f1");

    digi_clock = 24'h010007;
    AM         = 1'b1;
    run_to(2, "f2");
    chk("lz_blank", {an, seg, dp},
        {6'h3E, 7'h7F, 1'b1});
    run_to(10, "f2");
    chk("am_idx1", {an, seg, dp},
        {6'h3D, 7'b1111001, 1'b1});
    run_to(42, "f2");
    chk("am_idx5", {an, seg, dp},
        {6'h1F, 7'b1111000, 1'b1});
    run_to(0, "f2");

    digi_clock = 24'h123456;
    AM         = 1'b0;
    run_to(26, "tear");
    digi_clock = 24'h123457;
    run_to(42, "tear");
    chk("tear_old", {an, seg, dp},
        {6'h1F, 7'b0000010, 1'b0});
    run_to(0, "tear");
    run_to(10, "tear2");
    chk("tear_colon", {an, seg, dp},
        {6'h3D, 7'b0100100, 1'b1});
    run_to(42, "tear2");
    chk("tear_new", {an, seg, dp},
        {6'h1F, 7'b1111000, 1'b0});
    run_to(0, "tear2");

    digi_clock = 24'hA00000;
    run_to(2, "inv");
    chk("dash", {an, seg, dp},
        {6'h3E, 7'b0111111, 1'b1});
    run_to(19, "inv");
    lamp_test = 1'b1;
    tick("lamp_on");
    chk("lamp", {an, seg, dp},
        {6'h3B, 7'h00, 1'b0});
    lamp_test = 1'b0;
    tick("lamp_off");
    chk("lamp_rel", {an, seg, dp},
        {6'h3B, 7'b1000000, 1'b1});

    run_to(36, "pre_rst");
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst", {an, seg, dp},
        {6'h3F, 7'h7F, 1'b1});
    @(negedge clk);
    chk("rst_held", {an, seg, dp},
        {6'h3F, 7'h7F, 1'b1});
    digi_clock = 24'h123456;
    pos        = 0;
    reset_n    = 1'b1;
    tick("rst2_e1");
    tick("rst2_e2");
    chk("rst2_idx0", {an, seg, dp},
        {6'h3E, 7'b1111001, 1'b1});

    for (int i = 0; i < 8 * FRAME; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0)
          digi_clock = 24'($urandom);
        else
          for (int k = 0; k < 6; k++)
            digi_clock[4*k +: 4] =
              4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 15) == 0)
        AM = 1'($urandom);
      lamp_test = ($urandom_range(0, 7) == 0);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
